// File: rtl/mem_regfile_irq.sv
// rtl/mem_regfile_irq.sv - BRAM-port register file with byte lanes, RO masking, write pulses and W1C interrupts
module mem_regfile_irq #(
  parameter int Naddr = 4,
  parameter int Nbyte = 4,
  parameter logic [2**Naddr-1:0] RO_MASK = '0,
  parameter int ISR_ADDR = 2,
  parameter int IER_ADDR = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [Nbyte-1:0]                   we,
  input  logic [Naddr-1:0]                   addr,
  input  logic [8*Nbyte-1:0]                 wr_data,
  output logic [8*Nbyte-1:0]                 rd_data,
  output logic [(2**Naddr)*8*Nbyte-1:0]      reg_val,
  output logic [(2**Naddr)*8*Nbyte-1:0]      pul_val,
  input  logic [(2**Naddr)*8*Nbyte-1:0]      read_val,
  input  logic [8*Nbyte-1:0]                 irq_event,
  output logic                               irq
);

  localparam int Nregs = 2**Naddr;
  localparam int W     = 8*Nbyte;

  // The interrupt registers are always writable, whatever RO_MASK says.
  localparam logic [Nregs-1:0] RO_EFF = RO_MASK
                                        & ~(Nregs'(1) << ISR_ADDR)
                                        & ~(Nregs'(1) << IER_ADDR);
  localparam logic [Naddr-1:0] ISR_A = Naddr'(ISR_ADDR);
  localparam logic [Naddr-1:0] IER_A = Naddr'(IER_ADDR);

  if (ISR_ADDR == IER_ADDR || ISR_ADDR < 0 || IER_ADDR < 0 ||
      ISR_ADDR >= Nregs || IER_ADDR >= Nregs) begin : g_bad_irq_addr
    $fatal(1, "mem_regfile_irq: ISR_ADDR/IER_ADDR must differ and be below Nregs");
  end

  // regs[ISR_ADDR] holds the interrupt status itself, so reg_val mirrors it for free.
  logic [W-1:0] regs [Nregs];
  logic [W-1:0] wmask;
  logic [W-1:0] clr;
  logic         wr;

  // Expand byte enables to a bit mask and derive the W1C clear vector.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < Nbyte; b++) begin
      wmask[b*8 +: 8] = {8{we[b]}};
    end
    wr  = en & (|we);
    clr = (wr && addr == ISR_A) ? (wr_data & wmask) : '0;
  end

  // Register storage: byte-lane writes, RO registers frozen, ISR sticky with events winning over clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Nregs; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < Nregs; i++) begin
        if (i == ISR_ADDR) begin
          regs[i] <= (regs[i] & ~clr) | irq_event;
        end else if (wr && addr == Naddr'(i) && !RO_EFF[i]) begin
          regs[i] <= (regs[i] & ~wmask) | (wr_data & wmask);
        end
      end
    end
  end

  for (genvar g = 0; g < Nregs; g++) begin : g_reg_val
    assign reg_val[g*W +: W] = regs[g];
  end

  // Read-first registered read; holds when no access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (en) begin
      rd_data <= RO_EFF[addr] ? read_val[addr*W +: W] : regs[addr];
    end
  end

  // One-cycle write pulses, also for RO addresses so they can act as command strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pul_val <= '0;
    end else begin
      pul_val <= '0;
      if (wr && addr != ISR_A) pul_val[addr*W +: W] <= wr_data & wmask;
    end
  end

  // Interrupt request registered from enabled status bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(regs[ISR_A] & regs[IER_A]);
  end

endmodule

// File: tb/tb_mem_regfile_irq.sv
// tb/tb_mem_regfile_irq.sv - scoreboard bench for mem_regfile_irq
module tb_mem_regfile_irq;

  localparam int NA = 4;
  localparam int NR = 16;
  localparam int NB = 4;
  localparam int W  = 32;
  localparam int ISR = 2;
  localparam int IER = 3;
  localparam logic [NR-1:0] RO = 16'h004C;

  logic              clk;
  logic              reset;
  logic              en;
  logic [NB-1:0]     we;
  logic [NA-1:0]     addr;
  logic [W-1:0]      wr_data;
  logic [W-1:0]      rd_data;
  logic [NR*W-1:0]   reg_val;
  logic [NR*W-1:0]   pul_val;
  logic [NR*W-1:0]   read_val;
  logic [W-1:0]      irq_event;
  logic              irq;

  mem_regfile_irq #(
    .Naddr(NA), .Nbyte(NB), .RO_MASK(RO), .ISR_ADDR(ISR), .IER_ADDR(IER)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .reg_val(reg_val),
    .pul_val(pul_val), .read_val(read_val), .irq_event(irq_event), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_reg [NR];
  logic [W-1:0] rv    [NR];
  logic [W-1:0] m_rd;
  logic [W-1:0] rd_q  [$];

  task automatic check(input string tag, input logic [NR*W-1:0] got, input logic [NR*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_ro(input int a);
    return RO[a] && a != ISR && a != IER;
  endfunction

  function automatic logic [W-1:0] lane_mask(input logic [NB-1:0] w);
    logic [W-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) if (w[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [NR*W-1:0] flat_regs();
    logic [NR*W-1:0] v;
    for (int i = 0; i < NR; i++) v[i*W +: W] = m_reg[i];
    return v;
  endfunction

  // One clock of stimulus with model update and output checks after the edge.
  task automatic access(input logic e, input logic [NB-1:0] w, input int a,
                        input logic [W-1:0] d, input logic [W-1:0] ev);
    logic [W-1:0]    m, clr;
    logic [NR*W-1:0] exp_pul;
    logic            exp_irq;
    en = e; we = w; addr = NA'(a); wr_data = d; irq_event = ev;
    m       = lane_mask(w);
    exp_irq = |(m_reg[ISR] & m_reg[IER]);
    exp_pul = '0;
    clr     = '0;
    if (e) rd_q.push_back(is_ro(a) ? rv[a] : m_reg[a]);
    if (e && |w) begin
      if (a == ISR) clr = d & m;
      else begin
        exp_pul[a*W +: W] = d & m;
        if (!is_ro(a)) m_reg[a] = (m_reg[a] & ~m) | (d & m);
      end
    end
    m_reg[ISR] = (m_reg[ISR] & ~clr) | ev;
    @(posedge clk); #1;
    if (e) m_rd = rd_q.pop_front();
    check("rd_data", rd_data, m_rd);
    check("pul_val", pul_val, exp_pul);
    check("irq", irq, exp_irq);
    check("reg_val", reg_val, flat_regs());
    en = 0; we = '0; irq_event = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      rv[i] = 32'hC0DE0000 | i;
    end
    rv[6] = 32'h12345678;
    for (int i = 0; i < NR; i++) read_val[i*W +: W] = rv[i];
    m_rd = '0;
    reset = 1; en = 0; we = '0; addr = '0; wr_data = '0; irq_event = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_rd", rd_data, 0);
    check("rst_irq", irq, 0);
    check("rst_reg", reg_val, 0);

    // Byte lanes
    access(1, 4'b1111, 5, 32'hAABBCCDD, 0);
    access(1, 4'b0101, 5, 32'h11223344, 0);
    check("pul5", pul_val[5*W +: W], 32'h00220044);
    access(1, 4'b0000, 5, 0, 0);
    check("pul5_gone", pul_val[5*W +: W], 0);
    check("bl5", rd_data, 32'hAA22CC44);

    // RO mask
    access(1, 4'b1111, 6, 32'hFFFFFFFF, 0);
    check("ro6_reg", reg_val[6*W +: W], 0);
    check("ro6_pul", pul_val[6*W +: W], 32'hFFFFFFFF);
    access(1, 4'b0000, 6, 0, 0);
    check("ro6_rd", rd_data, 32'h12345678);

    // Read-first
    access(1, 4'b1111, 4, 32'h5, 0);
    check("rf_old", rd_data, 0);
    access(1, 4'b0000, 4, 0, 0);
    check("rf_new", rd_data, 32'h5);

    // Interrupt with IER enabled (IER bit is set in RO_MASK but must stay writable)
    access(1, 4'b1111, IER, 32'h1, 0);
    access(0, 4'b0000, 0, 0, 32'h1);
    check("isr_set", reg_val[ISR*W +: W], 32'h1);
    check("irq_n1", irq, 0);
    access(0, 4'b0000, 0, 0, 0);
    check("irq_n2", irq, 1);
    access(1, 4'b1111, ISR, 32'h1, 0);
    check("isr_clr", reg_val[ISR*W +: W], 0);
    check("irq_c1", irq, 1);
    access(0, 4'b0000, 0, 0, 0);
    check("irq_c2", irq, 0);

    // Interrupt with IER disabled
    access(1, 4'b1111, IER, 32'h0, 0);
    access(0, 4'b0000, 0, 0, 32'h1);
    repeat (3) access(0, 4'b0000, 0, 0, 0);
    check("irq_masked", irq, 0);
    check("isr_masked", reg_val[ISR*W +: W], 32'h1);
    access(1, 4'b1111, ISR, 32'h1, 0);

    // Clear/event collision and we=0 at ISR
    access(0, 4'b0000, 0, 0, 32'h8);
    access(1, 4'b1111, ISR, 32'h8, 32'h8);
    check("collide", reg_val[ISR*W +: W], 32'h8);
    access(1, 4'b0000, ISR, 32'hFFFFFFFF, 0);
    check("isr_rd", rd_data, 32'h8);
    check("isr_keep", reg_val[ISR*W +: W], 32'h8);

    // Random traffic against the model
    for (int k = 0; k < 40; k++) begin
      access(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, NR-1),
             $urandom, ($urandom_range(0, 3) == 0) ? 32'(1 << $urandom_range(0, 7)) : 32'h0);
    end

    // Asynchronous reset in the middle of a read
    access(1, 4'b1111, 5, 32'hDEADBEEF, 0);
    access(1, 4'b1111, IER, 32'hFFFFFFFF, 32'h10);
    access(0, 4'b0000, 0, 0, 0);
    check("pre_irq", irq, 1);
    en = 1; we = '0; addr = 4'd5;
    #2 reset = 1;
    #1;
    check("mid_rd", rd_data, 0);
    check("mid_irq", irq, 0);
    check("mid_reg", reg_val, 0);
    check("mid_pul", pul_val, 0);
    we = 4'b1111; addr = 4'd4; wr_data = 32'h77; irq_event = 32'h1;
    @(posedge clk); #1;
    check("held_reg", reg_val, 0);
    check("held_pul", pul_val, 0);
    check("held_rd", rd_data, 0);
    en = 0; we = '0; irq_event = '0;
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_regfile_irq.md
Name: mem_regfile_irq

Overview:
- Parametrised successor to the team's BRAM-port register file.
- Adds byte-lane write enables, per-register read-only masking, and write-pulse outputs.
- Adds a sticky write-1-to-clear interrupt status register with an enable register and a registered irq output.
- Sits between the PS BRAM-controller port and PL logic; one instance per subsystem that needs software control plus interrupts.

Parameters:
- Naddr, 4, address width in words; Nregs = 2**Naddr registers.
- Nbyte, 4, bytes per register; W = 8*Nbyte data bits.
- RO_MASK, {Nregs{1'b0}}, bit i=1 makes register i read-only: reads return read_val[i] and writes do not update reg_val[i].
- ISR_ADDR, 2, word address of the interrupt status register (W1C).
- IER_ADDR, 3, word address of the interrupt enable register.

Ports:
- clk  in  1  register clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  access strobe
- we  in  Nbyte  byte write enables; we==0 with en=1 is a read
- addr  in  Naddr  word address
- wr_data  in  W  write data
- rd_data  out  W  read data, one-cycle latency
- reg_val  out  Nregs x W  stored register contents
- pul_val  out  Nregs x W  one-cycle write pulses
- read_val  in  Nregs x W  status values returned for RO registers
- irq_event  in  W  interrupt event inputs, sampled every cycle
- irq  out  1  registered interrupt request

Behaviour:
- Reset (asynchronous, active-high):
  - reg_val, isr, rd_data, pul_val and irq all go to 0 immediately.
  - A read in flight when reset asserts returns 0.
  - No access is recognised while reset is high.
- Write (en=1, |we=1):
  - Ordinary writable register (not RO, not ISR_ADDR): at the next edge, each byte b with we[b]=1 takes wr_data byte b; other bytes hold.
  - RO register: reg_val is unchanged.
  - ISR_ADDR: W1C. clr = wr_data masked by we bytes.
- pul_val:
  - For one cycle after any write, pul_val[addr] = wr_data masked by we bytes, including RO addresses. This lets RO addresses act as command strobes.
  - pul_val[ISR_ADDR] is always 0.
  - All other words and cycles read 0.
- Read:
  - Every en=1 cycle, rd_data is registered at the next edge with the pre-write value (read-first).
  - Source: RO register → read_val[addr]; ISR_ADDR → isr; otherwise → reg_val[addr].
  - rd_data holds its value when en=0.
- ISR update:
  - isr <= (isr & ~clr) | irq_event every cycle; clr = 0 when ISR_ADDR is not being written.
  - An event in the same cycle as a clear of the same bit wins (bit stays 1).
  - reg_val[ISR_ADDR] mirrors isr.
- IER: ordinary writable register; no special write behaviour.
- irq:
  - irq <= |(isr & reg_val[IER_ADDR]).
  - Latency: event at cycle n → isr bit set after edge n+1 → irq after edge n+2.
  - Clear latency: W1C at cycle n → irq drops after edge n+2, provided no new event.
- Constraints:
  - ISR_ADDR != IER_ADDR; both < Nregs.
  - RO_MASK bits at ISR_ADDR and IER_ADDR are ignored.
  - Elaboration fails if the address constraint is violated.
- Address range: addr width equals Naddr, so there are no out-of-range accesses.

Test Plan:
1. Reset: assert reset mid-read → rd_data=0, irq=0, all reg_val=0 asynchronously, before any clock edge.
2. Byte lanes: write 0xAABBCCDD to addr 5 with we=4'b1111, then 0x11223344 with we=4'b0101 → read of 5 returns 0xAA22CC44; pul_val[5] shows 0x00220044 for exactly one cycle.
3. RO mask: RO_MASK bit 6 set, read_val[6]=0x12345678; write 0xFFFFFFFF to addr 6 → reg_val[6] stays 0, pul_val[6]=0xFFFFFFFF for one cycle, read of 6 returns 0x12345678.
4. Read-first: write 0x5 to addr 4 and read it in the same cycle → rd_data returns the old value 0x0; the next read returns 0x5.
5. Interrupt: IER=0x1; pulse irq_event[0] for one cycle at cycle n → isr=0x1 after edge n+1, irq=1 after edge n+2; W1C 0x1 to ISR_ADDR → irq=0 two cycles later. Repeat with IER=0 → irq stays 0 while isr=0x1.
6. Clear/event collision: W1C bit 3 in the same cycle irq_event[3]=1 → isr bit 3 remains 1; W1C with we=4'b0000 at ISR_ADDR is treated as a read and isr is unchanged.
